// File: rtl/cache_axi_bridge_pkg.sv
// Shared constants and types for the cache-to-AXI4 bridge: request type
// encodings, fixed AXI IDs, burst type, line geometry and FSM state types.
package cache_axi_bridge_pkg;

  // Cache request type encodings (rd_type / wr_type)
  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  // Fixed AXI transaction attributes
  localparam logic [3:0] AXI_RD_ID      = 4'd0;
  localparam logic [3:0] AXI_WR_ID      = 4'd1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // A 16-byte line moves as four 32-bit beats
  localparam logic [7:0] LINE_LEN   = 8'd3;
  localparam logic [2:0] LINE_SIZE  = 3'b010;
  localparam logic [3:0] LINE_WSTRB = 4'b1111;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  function automatic logic is_line(input logic [2:0] req_type);
    return req_type == TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_axi_bridge.sv
// Bridge between a simple cache request interface and AXI4. One read and one
// write may be outstanding at a time; reads to a line with a write in flight
// are held off until the write response has been taken.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  // cache read port
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [1:0]   ret_last,
  output logic [31:0]  ret_data,
  // cache write port
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI read address
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI write address
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  // AXI write data
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI write response
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_t    r_rd_state;
  rd_state_t    w_rd_state_nxt;
  logic [31:0]  r_rd_addr;
  logic [2:0]   r_rd_type;

  wr_state_t    r_wr_state;
  wr_state_t    w_wr_state_nxt;
  logic [31:0]  r_wr_addr;
  logic [2:0]   r_wr_type;
  logic [3:0]   r_wr_strb;
  logic [127:0] r_wr_data;
  logic [1:0]   r_beat;
  logic         r_aw_done;
  logic         r_w_done;

  logic         w_rd_accept;
  logic         w_wr_accept;
  logic         w_rd_conflict;
  logic         w_rd_is_line;
  logic         w_wr_is_line;
  logic         w_aw_hs;
  logic         w_w_hs;
  logic         w_aw_ok;
  logic         w_w_ok;
  logic [31:0]  w_line_word;
  logic         w_unused_resp;

  // Response IDs and status codes carry nothing the cache needs
  assign w_unused_resp = ^{rid, rresp, bid, bresp};

  assign w_rd_accept  = rd_req & rd_rdy;
  assign w_wr_accept  = wr_req & wr_rdy;
  assign w_rd_is_line = is_line(r_rd_type);
  assign w_wr_is_line = is_line(r_wr_type);

  // A read must not overtake a write to the same line, whether that write is
  // already in flight or being accepted in this very cycle.
  assign w_rd_conflict =
      ((r_wr_state != W_IDLE) && (r_wr_addr[31:4] == rd_addr[31:4])) ||
      (w_wr_accept && (wr_addr[31:4] == rd_addr[31:4]));

  assign rd_rdy = (r_rd_state == R_IDLE) && !w_rd_conflict;
  assign wr_rdy = (r_wr_state == W_IDLE);

  // ---------------- read channel ----------------

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) r_rd_state <= R_IDLE;
    else         r_rd_state <= w_rd_state_nxt;
  end

  // Read FSM next-state logic
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_rd_accept)      w_rd_state_nxt = R_ADDR;
      R_ADDR:  if (arready)          w_rd_state_nxt = R_DATA;
      R_DATA:  if (rvalid && rlast)  w_rd_state_nxt = R_IDLE;
      default:                       w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Capture read request attributes on accept
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_addr <= '0;
      r_rd_type <= '0;
    end else if (w_rd_accept) begin
      r_rd_addr <= rd_addr;
      r_rd_type <= rd_type;
    end
  end

  assign arid    = AXI_RD_ID;
  assign arburst = AXI_BURST_INCR;
  assign araddr  = w_rd_is_line ? {r_rd_addr[31:4], 4'b0000} : r_rd_addr;
  assign arlen   = w_rd_is_line ? LINE_LEN : 8'd0;
  assign arsize  = w_rd_is_line ? LINE_SIZE : {1'b0, r_rd_type[1:0]};
  assign arvalid = (r_rd_state == R_ADDR);
  assign rready  = (r_rd_state == R_DATA);

  // Read beats pass straight through to the cache
  assign ret_valid = rready & rvalid;
  assign ret_data  = rdata;
  assign ret_last  = {1'b0, rlast};

  // ---------------- write channel ----------------

  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  // AW and W complete independently; each may finish now or have finished earlier
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done  | (w_w_hs & wlast);

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) r_wr_state <= W_IDLE;
    else         r_wr_state <= w_wr_state_nxt;
  end

  // Write FSM next-state logic
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_wr_accept)        w_wr_state_nxt = W_SEND;
      W_SEND:  if (w_aw_ok && w_w_ok)  w_wr_state_nxt = W_RESP;
      W_RESP:  if (bvalid)             w_wr_state_nxt = W_IDLE;
      default:                         w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Capture write request attributes and data on accept
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_addr <= '0;
      r_wr_type <= '0;
      r_wr_strb <= '0;
      r_wr_data <= '0;
    end else if (w_wr_accept) begin
      r_wr_addr <= wr_addr;
      r_wr_type <= wr_type;
      r_wr_strb <= wr_wstrb;
      r_wr_data <= wr_data;
    end
  end

  // Track AW completion, W completion and the current beat while sending;
  // everything is cleared whenever the FSM is not staying in W_SEND.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_beat    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_wr_state == W_SEND && w_wr_state_nxt == W_SEND) begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) begin
        if (wlast) r_w_done <= 1'b1;
        else       r_beat   <= r_beat + 2'd1;
      end
    end else begin
      r_beat    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end
  end

  // Select the 32-bit word of the line for the current beat
  always_comb begin
    w_line_word = r_wr_data[31:0];
    case (r_beat)
      2'd0: w_line_word = r_wr_data[31:0];
      2'd1: w_line_word = r_wr_data[63:32];
      2'd2: w_line_word = r_wr_data[95:64];
      2'd3: w_line_word = r_wr_data[127:96];
      default: w_line_word = r_wr_data[31:0];
    endcase
  end

  assign awid    = AXI_WR_ID;
  assign awburst = AXI_BURST_INCR;
  assign awaddr  = w_wr_is_line ? {r_wr_addr[31:4], 4'b0000} : r_wr_addr;
  assign awlen   = w_wr_is_line ? LINE_LEN : 8'd0;
  assign awsize  = w_wr_is_line ? LINE_SIZE : {1'b0, r_wr_type[1:0]};
  assign awvalid = (r_wr_state == W_SEND) && !r_aw_done;

  assign wvalid  = (r_wr_state == W_SEND) && !r_w_done;
  assign wdata   = w_wr_is_line ? w_line_word : r_wr_data[31:0];
  assign wstrb   = w_wr_is_line ? LINE_WSTRB : r_wr_strb;
  assign wlast   = w_wr_is_line ? (r_beat == 2'd3) : 1'b1;
  assign bready  = (r_wr_state == W_RESP);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed self-checking bench for cache_axi_bridge: reset, line/single
// reads and writes, same-line read blocking, concurrent accept, mid-read reset.
module tb_cache_axi_bridge;
  import cache_axi_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [1:0]   ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int n_pass  = 0;
  int n_total = 0;

  cache_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick; tick;
    #1;
    n_total++;
    if ({arvalid, awvalid, wvalid, rready, bready, ret_valid, rd_rdy, wr_rdy} !== 8'b0000_0011)
      $display("FAIL reset_outputs: got %b want %b",
               {arvalid, awvalid, wvalid, rready, bready, ret_valid, rd_rdy, wr_rdy}, 8'b0000_0011);
    else n_pass++;
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_line_read;
    logic [1:0] exp_last;
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h1C00_0010;
    #1;
    n_total++;
    if (rd_rdy !== 1'b1) $display("FAIL lr_rd_rdy: got %b want 1", rd_rdy); else n_pass++;
    tick;
    rd_req = 1'b0; rd_addr = '0;
    #1;
    n_total++;
    if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h1C00_0010, 8'd3, 3'd2, 2'd1, 4'd0})
      $display("FAIL lr_ar_fields: got %h want %h", {arvalid, araddr, arlen, arsize, arburst, arid},
               {1'b1, 32'h1C00_0010, 8'd3, 3'd2, 2'd1, 4'd0});
    else n_pass++;
    tick;
    #1;
    n_total++;
    if ({arvalid, araddr} !== {1'b1, 32'h1C00_0010})
      $display("FAIL lr_ar_hold: got %h want %h", {arvalid, araddr}, {1'b1, 32'h1C00_0010});
    else n_pass++;
    tick;
    arready = 1'b1;
    #1;
    tick;
    arready = 1'b0;
    #1;
    n_total++;
    if ({arvalid, rready, ret_valid} !== 3'b010)
      $display("FAIL lr_data_state: got %b want 010", {arvalid, rready, ret_valid});
    else n_pass++;
    for (int b = 0; b < 4; b++) begin
      rvalid = 1'b1; rdata = 32'hA5A5_0000 + b; rlast = (b == 3);
      exp_last = (b == 3) ? 2'b01 : 2'b00;
      #1;
      n_total++;
      if ({ret_valid, ret_data, ret_last} !== {1'b1, 32'hA5A5_0000 + b, exp_last})
        $display("FAIL lr_beat%0d: got %h want %h", b, {ret_valid, ret_data, ret_last},
                 {1'b1, 32'hA5A5_0000 + b, exp_last});
      else n_pass++;
      tick;
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    n_total++;
    if ({rready, rd_rdy, ret_valid} !== 3'b010)
      $display("FAIL lr_done: got %b want 010", {rready, rd_rdy, ret_valid});
    else n_pass++;
  endtask

  task automatic test_line_write;
    logic [31:0] exp_d [7];
    logic        pat   [7];
    exp_d = '{32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222,
              32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h1C00_0020; wr_wstrb = 4'b0000;
    wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    #1;
    n_total++;
    if (wr_rdy !== 1'b1) $display("FAIL lw_wr_rdy: got %b want 1", wr_rdy); else n_pass++;
    tick;
    wr_req = 1'b0; wr_data = '0;
    #1;
    n_total++;
    if ({awvalid, awaddr, awlen, awsize, awburst, awid} !== {1'b1, 32'h1C00_0020, 8'd3, 3'd2, 2'd1, 4'd1})
      $display("FAIL lw_aw_fields: got %h want %h", {awvalid, awaddr, awlen, awsize, awburst, awid},
               {1'b1, 32'h1C00_0020, 8'd3, 3'd2, 2'd1, 4'd1});
    else n_pass++;
    awready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      wready = pat[c];
      #1;
      n_total++;
      if ({wvalid, wdata, wstrb, wlast} !== {1'b1, exp_d[c], 4'b1111, (c == 6)})
        $display("FAIL lw_wcycle%0d: got %h want %h", c, {wvalid, wdata, wstrb, wlast},
                 {1'b1, exp_d[c], 4'b1111, (c == 6)});
      else n_pass++;
      if (c == 1) begin
        n_total++;
        if (awvalid !== 1'b0) $display("FAIL lw_aw_drop: got %b want 0", awvalid); else n_pass++;
      end
      tick;
      awready = 1'b0;
    end
    wready = 1'b0;
    #1;
    n_total++;
    if ({wvalid, bready, wr_rdy} !== 3'b010)
      $display("FAIL lw_resp_wait: got %b want 010", {wvalid, bready, wr_rdy});
    else n_pass++;
    tick;
    bvalid = 1'b1;
    #1;
    tick;
    bvalid = 1'b0;
    #1;
    n_total++;
    if ({wr_rdy, bready} !== 2'b10)
      $display("FAIL lw_after_b: got %b want 10", {wr_rdy, bready});
    else n_pass++;
  endtask

  task automatic test_single_write;
    wr_req = 1'b1; wr_type = TYPE_BYTE; wr_addr = 32'h1C00_0003; wr_wstrb = 4'b1000;
    wr_data = {96'h0, 32'hDEAD_BEEF};
    #1;
    tick;
    wr_req = 1'b0; awready = 1'b0; wready = 1'b1;
    #1;
    n_total++;
    if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h1C00_0003, 8'd0, 3'd0})
      $display("FAIL sw_aw_fields: got %h want %h", {awvalid, awaddr, awlen, awsize},
               {1'b1, 32'h1C00_0003, 8'd0, 3'd0});
    else n_pass++;
    n_total++;
    if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'hDEAD_BEEF, 4'b1000, 1'b1})
      $display("FAIL sw_w_fields: got %h want %h", {wvalid, wdata, wstrb, wlast},
               {1'b1, 32'hDEAD_BEEF, 4'b1000, 1'b1});
    else n_pass++;
    tick;
    wready = 1'b0;
    #1;
    n_total++;
    if ({awvalid, wvalid, bready} !== 3'b100)
      $display("FAIL sw_w_before_aw: got %b want 100", {awvalid, wvalid, bready});
    else n_pass++;
    awready = 1'b1;
    tick;
    awready = 1'b0;
    #1;
    n_total++;
    if ({awvalid, bready} !== 2'b01)
      $display("FAIL sw_resp: got %b want 01", {awvalid, bready});
    else n_pass++;
    bvalid = 1'b1;
    tick;
    bvalid = 1'b0;
    #1;
    n_total++;
    if (wr_rdy !== 1'b1) $display("FAIL sw_idle: got %b want 1", wr_rdy); else n_pass++;
  endtask

  task automatic test_same_line_block;
    wr_req = 1'b1; wr_type = TYPE_LINE; wr_addr = 32'h1C00_0040; wr_wstrb = 4'b0000;
    wr_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h1C00_0044;
    awready = 1'b1; wready = 1'b1;
    #1;
    n_total++;
    if ({wr_rdy, rd_rdy} !== 2'b10)
      $display("FAIL sl_accept_cycle: got %b want 10", {wr_rdy, rd_rdy});
    else n_pass++;
    tick;
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if ({rd_rdy, arvalid} !== 2'b00)
        $display("FAIL sl_send%0d: got %b want 00", i, {rd_rdy, arvalid});
      else n_pass++;
      tick;
    end
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if ({rd_rdy, arvalid, bready} !== 3'b001)
        $display("FAIL sl_resp%0d: got %b want 001", i, {rd_rdy, arvalid, bready});
      else n_pass++;
      tick;
    end
    bvalid = 1'b1;
    #1;
    n_total++;
    if (rd_rdy !== 1'b0) $display("FAIL sl_b_cycle: got %b want 0", rd_rdy); else n_pass++;
    tick;
    bvalid = 1'b0;
    #1;
    n_total++;
    if ({rd_rdy, arvalid} !== 2'b10)
      $display("FAIL sl_after_b: got %b want 10", {rd_rdy, arvalid});
    else n_pass++;
    tick;
    rd_req = 1'b0;
    #1;
    n_total++;
    if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h1C00_0044, 8'd0, 3'd2})
      $display("FAIL sl_ar_fields: got %h want %h", {arvalid, araddr, arlen, arsize},
               {1'b1, 32'h1C00_0044, 8'd0, 3'd2});
    else n_pass++;
    arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
    #1;
    n_total++;
    if ({ret_valid, ret_data, ret_last} !== {1'b1, 32'h1234_5678, 2'b01})
      $display("FAIL sl_ret: got %h want %h", {ret_valid, ret_data, ret_last},
               {1'b1, 32'h1234_5678, 2'b01});
    else n_pass++;
    tick;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_concurrent;
    wr_req = 1'b1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0100; wr_wstrb = 4'b1111;
    wr_data = {96'h0, 32'hCAFE_F00D};
    rd_req = 1'b1; rd_type = TYPE_WORD; rd_addr = 32'h0000_0200;
    #1;
    n_total++;
    if ({rd_rdy, wr_rdy} !== 2'b11)
      $display("FAIL cc_accept: got %b want 11", {rd_rdy, wr_rdy});
    else n_pass++;
    tick;
    wr_req = 1'b0; rd_req = 1'b0;
    #1;
    n_total++;
    if ({arvalid, awvalid, araddr, awaddr} !== {2'b11, 32'h0000_0200, 32'h0000_0100})
      $display("FAIL cc_both_valid: got %h want %h", {arvalid, awvalid, araddr, awaddr},
               {2'b11, 32'h0000_0200, 32'h0000_0100});
    else n_pass++;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    tick;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0BAD_CAFE; bvalid = 1'b1;
    #1;
    n_total++;
    if ({ret_valid, bready} !== 2'b11)
      $display("FAIL cc_completion: got %b want 11", {ret_valid, bready});
    else n_pass++;
    tick;
    rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
    #1;
    n_total++;
    if ({rd_rdy, wr_rdy} !== 2'b11)
      $display("FAIL cc_idle: got %b want 11", {rd_rdy, wr_rdy});
    else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    rd_req = 1'b1; rd_type = TYPE_LINE; rd_addr = 32'h1C00_0080;
    #1;
    tick;
    rd_req = 1'b0; arready = 1'b1;
    tick;
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b0; rdata = 32'hBEA7_0000;
    #1;
    n_total++;
    if (ret_valid !== 1'b1) $display("FAIL rm_beat1: got %b want 1", ret_valid); else n_pass++;
    tick;
    resetn = 1'b0; rdata = 32'hBEA7_0001;
    #1;
    tick;
    resetn = 1'b1;
    #1;
    n_total++;
    if ({rready, rd_rdy, ret_valid, arvalid} !== 4'b0100)
      $display("FAIL rm_abandon: got %b want 0100", {rready, rd_rdy, ret_valid, arvalid});
    else n_pass++;
    rvalid = 1'b0;
    tick;
  endtask

  initial begin
    resetn = 1'b0;
    rd_req = 1'b0; rd_type = '0; rd_addr = '0;
    wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
    arready = 1'b0; rid = 4'hF; rdata = '0; rresp = 2'b10; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'hF; bresp = 2'b10; bvalid = 1'b0;
    test_reset;
    test_line_read;
    test_line_write;
    test_single_write;
    test_same_line_block;
    test_concurrent;
    test_reset_mid_read;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case a scenario wedges the clocked flow
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

endmodule
